// File: rtl/sp_icache_ctrl_pkg.sv
// Shared types and defaults for the icache control-bus responder.
package sp_icache_ctrl_pkg;

    localparam int unsigned CNT_W_DEF = 32;

    // Responder sequencing states; DISABLED/ENABLED are the idle states.
    typedef enum logic [2:0] {
        ST_DISABLED,
        ST_ENABLED,
        ST_DRAIN,
        ST_FLUSH,
        ST_ACK
    } state_t;

    // Which 4-phase request is currently being served.
    typedef enum logic [1:0] {
        OP_NONE,
        OP_ENABLE,
        OP_DISABLE,
        OP_FLUSH
    } op_t;

    // True once the request being acknowledged has been withdrawn.
    function automatic logic req_released(op_t op, logic en, logic dis, logic fl);
        logic rel;
        case (op)
            OP_ENABLE:  rel = !en;
            OP_DISABLE: rel = !dis;
            OP_FLUSH:   rel = !fl;
            default:    rel = 1'b1;
        endcase
        return rel;
    endfunction

endpackage

// File: rtl/icache_inv_walker.sv
// Walks tag-RAM sets 0..NB_SETS-1 with a req/gnt handshake per set.
module icache_inv_walker #(
    parameter int unsigned NB_SETS = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       gnt,
    output logic                       req,
    output logic [$clog2(NB_SETS)-1:0] addr,
    output logic                       done_c
);

    localparam int unsigned AW = $clog2(NB_SETS);
    localparam logic [AW-1:0] LAST = AW'(NB_SETS - 1);

    // Last set accepted this cycle.
    assign done_c = req && gnt && (addr == LAST);

    // Set counter: advance only when the tag RAM grants the current set.
    always_ff @(posedge clk) begin
        if (rst) begin
            req  <= 1'b0;
            addr <= '0;
        end else if (start) begin
            req  <= 1'b1;
            addr <= '0;
        end else if (req && gnt) begin
            if (addr == LAST) begin
                req  <= 1'b0;
                addr <= '0;
            end else begin
                addr <= addr + AW'(1);
            end
        end
    end

endmodule

// File: rtl/sp_icache_ctrl_responder.sv
// Cache-side responder of the shared-icache control bus: enable/disable/flush
// sequencing, outstanding-refill tracking and optional perf counters.
// Perf counters are built only when ICACHE_CTRL_PERF_CNT_EN is defined.
module sp_icache_ctrl_responder
    import sp_icache_ctrl_pkg::*;
#(
    parameter int unsigned NB_SETS = 32,
    parameter int unsigned PEND_W  = 4,
    parameter int unsigned CNT_W   = CNT_W_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       ctrl_req_enable_i,
    output logic                       ctrl_ack_enable_o,
    input  logic                       ctrl_req_disable_i,
    output logic                       ctrl_ack_disable_o,
    input  logic                       flush_req_i,
    output logic                       flush_ack_o,
    output logic                       ctrl_pending_trans_o,
    input  logic                       icache_is_private_i,
    input  logic                       ctrl_clear_regs_i,
    input  logic                       ctrl_enable_regs_i,
    output logic [CNT_W-1:0]           ctrl_hit_count_o,
    output logic [CNT_W-1:0]           ctrl_trans_count_o,
    output logic [CNT_W-1:0]           ctrl_miss_count_o,
    input  logic                       fetch_valid_i,
    input  logic                       fetch_hit_i,
    input  logic                       refill_issue_i,
    input  logic                       refill_done_i,
    output logic                       cache_enable_o,
    output logic                       fetch_stall_o,
    output logic                       private_o,
    output logic                       inv_req_o,
    output logic [$clog2(NB_SETS)-1:0] inv_addr_o,
    input  logic                       inv_gnt_i
);

    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            state;
    op_t               op;
    logic [PEND_W-1:0] pend;
    logic [PEND_W-1:0] pend_nxt;
    logic              walk_start_c;
    logic              walk_done_c;
    logic              any_ack_c;

    assign any_ack_c    = ctrl_ack_enable_o || ctrl_ack_disable_o || flush_ack_o;
    assign walk_start_c = (state == ST_DRAIN) && (pend == '0) && (op == OP_FLUSH);

    icache_inv_walker #(.NB_SETS(NB_SETS)) u_walker (
        .clk    (clk_i),
        .rst    (rst_i),
        .start  (walk_start_c),
        .gnt    (inv_gnt_i),
        .req    (inv_req_o),
        .addr   (inv_addr_o),
        .done_c (walk_done_c)
    );

    // Outstanding-refill count, saturating at both ends.
    always_comb begin
        pend_nxt = pend;
        if (refill_issue_i && !refill_done_i && (pend != PEND_MAX)) begin
            pend_nxt = pend + PEND_W'(1);
        end else if (refill_done_i && !refill_issue_i && (pend != '0)) begin
            pend_nxt = pend - PEND_W'(1);
        end
    end

    // Pending register and its registered non-zero flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend                 <= '0;
            ctrl_pending_trans_o <= 1'b0;
        end else begin
            pend                 <= pend_nxt;
            ctrl_pending_trans_o <= (pend_nxt != '0);
        end
    end

    pend_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(refill_issue_i && !refill_done_i && (pend == PEND_MAX)))
        else $error("pending refill counter overflow");

    pend_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(refill_done_i && !refill_issue_i && (pend == '0)))
        else $error("pending refill counter underflow");

    // Request sequencer: accept in idle, drain, optionally walk tags, ack.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state              <= ST_DISABLED;
            op                 <= OP_NONE;
            cache_enable_o     <= 1'b0;
            fetch_stall_o      <= 1'b0;
            private_o          <= 1'b0;
            ctrl_ack_enable_o  <= 1'b0;
            ctrl_ack_disable_o <= 1'b0;
            flush_ack_o        <= 1'b0;
        end else begin
            case (state)
                ST_DISABLED, ST_ENABLED: begin
                    private_o <= icache_is_private_i;
                    if (!any_ack_c) begin
                        if (flush_req_i) begin
                            fetch_stall_o <= 1'b1;
                            op            <= OP_FLUSH;
                            state         <= ST_DRAIN;
                        end else if (ctrl_req_disable_i) begin
                            fetch_stall_o <= 1'b1;
                            op            <= OP_DISABLE;
                            if (pend == '0) begin
                                cache_enable_o     <= 1'b0;
                                ctrl_ack_disable_o <= 1'b1;
                                state              <= ST_ACK;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else if (ctrl_req_enable_i) begin
                            cache_enable_o    <= 1'b1;
                            ctrl_ack_enable_o <= 1'b1;
                            op                <= OP_ENABLE;
                            state             <= ST_ACK;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (walk_start_c) begin
                        state <= ST_FLUSH;
                    end else if (pend == '0) begin
                        cache_enable_o     <= 1'b0;
                        ctrl_ack_disable_o <= 1'b1;
                        state              <= ST_ACK;
                    end
                end
                ST_FLUSH: begin
                    if (walk_done_c) begin
                        flush_ack_o <= 1'b1;
                        state       <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (req_released(op, ctrl_req_enable_i, ctrl_req_disable_i, flush_req_i)) begin
                        ctrl_ack_enable_o  <= 1'b0;
                        ctrl_ack_disable_o <= 1'b0;
                        flush_ack_o        <= 1'b0;
                        fetch_stall_o      <= 1'b0;
                        op                 <= OP_NONE;
                        state              <= cache_enable_o ? ST_ENABLED : ST_DISABLED;
                    end
                end
                default: begin
                    state <= ST_DISABLED;
                end
            endcase
        end
    end

`ifdef ICACHE_CTRL_PERF_CNT_EN
    // Perf counters; clear has priority over counting.
    always_ff @(posedge clk_i) begin
        if (rst_i || ctrl_clear_regs_i) begin
            ctrl_trans_count_o <= '0;
            ctrl_hit_count_o   <= '0;
            ctrl_miss_count_o  <= '0;
        end else if (ctrl_enable_regs_i) begin
            ctrl_trans_count_o <= ctrl_trans_count_o + CNT_W'(fetch_valid_i);
            ctrl_hit_count_o   <= ctrl_hit_count_o + CNT_W'(fetch_valid_i && fetch_hit_i);
            ctrl_miss_count_o  <= ctrl_miss_count_o + CNT_W'(fetch_valid_i && !fetch_hit_i);
        end
    end
`else
    assign ctrl_trans_count_o = '0;
    assign ctrl_hit_count_o   = '0;
    assign ctrl_miss_count_o  = '0;

    logic unused_perf;
    assign unused_perf = ^{ctrl_clear_regs_i, ctrl_enable_regs_i, fetch_valid_i, fetch_hit_i};
`endif

endmodule

// File: tb/tb_sp_icache_ctrl_responder.sv
// Scoreboard bench for sp_icache_ctrl_responder: stimulus pushes expected
// responses, a negedge monitor pops and compares on acks, probes and
// invalidate handshakes.
module tb_sp_icache_ctrl_responder;

    localparam int unsigned NB_SETS = 32;
    localparam int unsigned PEND_W  = 4;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned AW      = $clog2(NB_SETS);

`ifdef ICACHE_CTRL_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             req_en, ack_en, req_dis, ack_dis, flush_req, flush_ack;
    logic             pending, is_private, clear_regs, enable_regs;
    logic [CNT_W-1:0] hit_cnt, trans_cnt, miss_cnt;
    logic             fetch_valid, fetch_hit, refill_issue, refill_done;
    logic             cache_en, stall, priv, inv_req, inv_gnt;
    logic [AW-1:0]    inv_addr;

    sp_icache_ctrl_responder #(
        .NB_SETS(NB_SETS), .PEND_W(PEND_W), .CNT_W(CNT_W)
    ) dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .ctrl_req_enable_i    (req_en),
        .ctrl_ack_enable_o    (ack_en),
        .ctrl_req_disable_i   (req_dis),
        .ctrl_ack_disable_o   (ack_dis),
        .flush_req_i          (flush_req),
        .flush_ack_o          (flush_ack),
        .ctrl_pending_trans_o (pending),
        .icache_is_private_i  (is_private),
        .ctrl_clear_regs_i    (clear_regs),
        .ctrl_enable_regs_i   (enable_regs),
        .ctrl_hit_count_o     (hit_cnt),
        .ctrl_trans_count_o   (trans_cnt),
        .ctrl_miss_count_o    (miss_cnt),
        .fetch_valid_i        (fetch_valid),
        .fetch_hit_i          (fetch_hit),
        .refill_issue_i       (refill_issue),
        .refill_done_i        (refill_done),
        .cache_enable_o       (cache_en),
        .fetch_stall_o        (stall),
        .private_o            (priv),
        .inv_req_o            (inv_req),
        .inv_addr_o           (inv_addr),
        .inv_gnt_i            (inv_gnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        bit          is_ack;
        logic [7:0]  obs;
        int          exp_cyc;
        bit          chk_cnt;
        logic [95:0] cnt;
    } ev_t;

    ev_t        ev_q[$];
    int         addr_q[$];
    int         cyc = 0;
    int         probe_cnt = 0;
    int         probe_seen = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [2:0] prev_acks = 3'b000;
    logic [7:0] obs_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [95:0] cnts(int t, int h, int m);
        return PERF ? {32'(t), 32'(h), 32'(m)} : 96'd0;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_ack(string name, logic [7:0] obs, int exp_cyc);
        ev_t e;
        e.name = name; e.is_ack = 1'b1; e.obs = obs; e.exp_cyc = exp_cyc;
        e.chk_cnt = 1'b0; e.cnt = '0;
        ev_q.push_back(e);
    endtask

    task automatic probe(string name, logic [7:0] obs, bit chk_cnt, logic [95:0] cnt);
        ev_t e;
        e.name = name; e.is_ack = 1'b0; e.obs = obs; e.exp_cyc = cyc;
        e.chk_cnt = chk_cnt; e.cnt = cnt;
        ev_q.push_back(e);
        probe_cnt++;
    endtask

    task automatic pop_cmp(bit is_ack);
        ev_t e;
        if (ev_q.size() == 0) begin
            check("unexpected_event", 128'(is_ack) + 128'd1, 128'd0);
        end else begin
            e = ev_q.pop_front();
            check({e.name, "_kind"}, 128'(is_ack), 128'(e.is_ack));
            check(e.name, 128'(obs_now), 128'(e.obs));
            if (is_ack) check({e.name, "_cycle"}, 128'(cyc), 128'(e.exp_cyc));
            if (e.chk_cnt) check({e.name, "_cnt"}, 128'({trans_cnt, hit_cnt, miss_cnt}), 128'(e.cnt));
        end
    endtask

    // Monitor: obs = {ack_en, ack_dis, flush_ack, cache_en, stall, pending, priv, inv_req}.
    always @(negedge clk) begin
        obs_now = {ack_en, ack_dis, flush_ack, cache_en, stall, pending, priv, inv_req};
        if (inv_req && inv_gnt) begin
            if (addr_q.size() == 0) check("inv_addr_unexpected", 128'(inv_addr) + 128'd1, 128'd0);
            else check("inv_addr", 128'(inv_addr), 128'(addr_q.pop_front()));
        end
        if ((obs_now[7:5] & ~prev_acks) != 3'b000) pop_cmp(1'b1);
        if (probe_seen != probe_cnt) begin
            probe_seen++;
            pop_cmp(1'b0);
        end
        prev_acks = obs_now[7:5];
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [9:0] pat;
        rst = 1'b1; req_en = 1'b0; req_dis = 1'b0; flush_req = 1'b0;
        is_private = 1'b0; clear_regs = 1'b0; enable_regs = 1'b0;
        fetch_valid = 1'b0; fetch_hit = 1'b0; refill_issue = 1'b0;
        refill_done = 1'b0; inv_gnt = 1'b1;

        // Reset state
        tick(2);
        probe("reset_state", 8'b0000_0000, 1'b1, cnts(0, 0, 0));
        tick(1);
        rst = 1'b0;
        is_private = 1'b1;
        tick(1);

        // Enable: 1-cycle ack, ack held until req drops, falls one cycle later
        t = cyc;
        expect_ack("enable_ack", 8'b1001_0010, t + 1);
        req_en = 1'b1;
        tick(3);
        req_en = 1'b0;
        probe("enable_ack_held", 8'b1001_0010, 1'b0, '0);
        tick(1);
        probe("enable_ack_drop", 8'b0001_0010, 1'b0, '0);

        // Disable with 3 refills outstanding
        tick(1);
        refill_issue = 1'b1;
        tick(3);
        refill_issue = 1'b0;
        req_dis = 1'b1;
        probe("pending_three", 8'b0001_0110, 1'b0, '0);
        tick(1);
        probe("drain_stall", 8'b0001_1110, 1'b0, '0);
        tick(2);
        probe("drain_no_ack", 8'b0001_1110, 1'b0, '0);
        tick(1);
        t = cyc;
        expect_ack("disable_ack", 8'b0100_1010, t + 4);
        refill_done = 1'b1;
        tick(3);
        refill_done = 1'b0;
        tick(3);
        req_dis = 1'b0;
        tick(1);
        probe("disabled_idle", 8'b0000_0010, 1'b0, '0);

        // Re-enable, then flush with gnt always high
        tick(1);
        t = cyc;
        expect_ack("enable2_ack", 8'b1001_0010, t + 1);
        req_en = 1'b1;
        tick(2);
        req_en = 1'b0;
        tick(2);
        t = cyc;
        for (int i = 0; i < int'(NB_SETS); i++) addr_q.push_back(i);
        flush_req = 1'b1;
        tick(10);
        probe("flush_walking", 8'b0001_1011, 1'b0, '0);
        expect_ack("flush_ack", 8'b0011_1010, t + int'(NB_SETS) + 2);
        tick(26);
        flush_req = 1'b0;
        tick(1);
        probe("flush_kept_enabled", 8'b0001_0010, 1'b0, '0);

        // Flush and disable together: flush first, disable after flush req drops
        tick(1);
        t = cyc;
        for (int i = 0; i < int'(NB_SETS); i++) addr_q.push_back(i);
        flush_req = 1'b1;
        req_dis = 1'b1;
        expect_ack("flush_first_ack", 8'b0011_1010, t + int'(NB_SETS) + 2);
        tick(36);
        flush_req = 1'b0;
        t = cyc;
        expect_ack("disable_after_flush_ack", 8'b0100_1010, t + 2);
        tick(4);
        req_dis = 1'b0;
        tick(1);
        probe("disabled_after_flush", 8'b0000_0010, 1'b0, '0);

        // Perf counters: 10 fetches, 7 hits
        enable_regs = 1'b1;
        pat = 10'b10_1101_1011;
        for (int i = 0; i < 10; i++) begin
            fetch_valid = 1'b1;
            fetch_hit = pat[i];
            tick(1);
        end
        fetch_valid = 1'b0;
        fetch_hit = 1'b0;
        probe("cnt_10_7_3", 8'b0000_0010, 1'b1, cnts(10, 7, 3));
        enable_regs = 1'b0;
        fetch_valid = 1'b1;
        fetch_hit = 1'b1;
        tick(2);
        fetch_valid = 1'b0;
        probe("cnt_hold_when_off", 8'b0000_0010, 1'b1, cnts(10, 7, 3));
        tick(1);
        enable_regs = 1'b1;
        clear_regs = 1'b1;
        fetch_valid = 1'b1;
        fetch_hit = 1'b1;
        tick(1);
        clear_regs = 1'b0;
        fetch_valid = 1'b0;
        fetch_hit = 1'b0;
        probe("cnt_clear_beats_fetch", 8'b0000_0010, 1'b1, cnts(0, 0, 0));
        fetch_valid = 1'b1;
        tick(1);
        fetch_valid = 1'b0;
        probe("cnt_single_miss", 8'b0000_0010, 1'b1, cnts(1, 0, 1));

        // Reset in the middle of a flush walk at set 5
        tick(1);
        for (int i = 0; i < 6; i++) addr_q.push_back(i);
        flush_req = 1'b1;
        tick(7);
        rst = 1'b1;
        flush_req = 1'b0;
        tick(1);
        probe("reset_mid_flush", 8'b0000_0000, 1'b1, cnts(0, 0, 0));
        tick(1);
        rst = 1'b0;
        tick(2);
        probe("post_reset_idle", 8'b0000_0010, 1'b0, '0);

        tick(3);
        check("queues_drained", 128'(ev_q.size() + addr_q.size()), 128'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
